if_fetch: RTL and testbench

//  Instruction-fetch engine; consumer side of the PC register's pc/stall/jump interface.

---
 rtl/if_fetch_pkg.sv | 11 +
 rtl/if_fetch_icache_dm.sv | 54 +++++
 rtl/if_fetch.sv | 150 +++++++++++++++
 tb/tb_if_fetch.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch engine: widths, zero word and FSM encodings.
package if_fetch_pkg;
  localparam int InstLen = 32;
  localparam int AddrLen = 32;
  localparam logic [InstLen-1:0] ZeroWord = '0;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_WAIT  = 1'b1
  } state_e;
endpackage

// File: rtl/if_fetch_icache_dm.sv
// Direct-mapped instruction cache: combinational lookup by PC, single-word fill.
// Only instantiated by if_fetch when ICACHE_EN is defined.
module icache_dm
  import if_fetch_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [AddrLen-1:0] lookup_pc,
  output logic               hit,
  output logic [InstLen-1:0] word,
  input  logic               fill_en,
  input  logic [AddrLen-1:0] fill_pc,
  input  logic [InstLen-1:0] fill_word
);
  localparam int Entries = 1 << IDX_W;
  localparam int TagW    = AddrLen - IDX_W - 2;

  logic [Entries-1:0] vld_q, vld_d;
  logic [TagW-1:0]    tag_q  [Entries];
  logic [InstLen-1:0] data_q [Entries];

  logic [IDX_W-1:0] lk_idx, fl_idx;
  logic [TagW-1:0]  lk_tag, fl_tag;
  logic [3:0]       unused_lo;

  assign lk_idx    = lookup_pc[IDX_W+1:2];
  assign lk_tag    = lookup_pc[AddrLen-1:IDX_W+2];
  assign fl_idx    = fill_pc[IDX_W+1:2];
  assign fl_tag    = fill_pc[AddrLen-1:IDX_W+2];
  assign unused_lo = {lookup_pc[1:0], fill_pc[1:0]};

  assign hit  = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign word = data_q[lk_idx];

  always_comb begin
    vld_d = vld_q;
    if (fill_en) vld_d[fl_idx] = 1'b1;
  end

  // Only valid bits are reset; tag/data are qualified by them.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) vld_q <= '0;
    else           vld_q <= vld_d;
  end

  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_q[fl_idx]  <= fl_tag;
      data_q[fl_idx] <= fill_word;
    end
  end
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles 4 little-endian bytes from a byte-wide memory port into a word
// for decode and drives the PC register's stall. Optional icache under `ICACHE_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ICACHE_IDX_W = 4
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  input  logic [AddrLen-1:0] pc_in,
  input  logic               flush_in,
  output logic               mem_req_out,
  input  logic               mem_gnt_in,
  output logic [AddrLen-1:0] mem_addr_out,
  input  logic [7:0]         mem_byte_in,
  output logic               stall_req_out,
  input  logic               id_stall_in,
  output logic               if_valid_out,
  output logic [AddrLen-1:0] if_pc_out,
  output logic [InstLen-1:0] if_inst_out
);
  state_e             state_q, state_d;
  logic [2:0]         iss_q, iss_d;
  logic [2:0]         rcv_q, rcv_d;
  logic               pend_q, pend_d;
  logic [InstLen-1:0] wbuf_q, wbuf_d;
  logic               vld_q, vld_d;
  logic [AddrLen-1:0] pc_q, pc_d;
  logic [InstLen-1:0] inst_q, inst_d;

  logic               cache_hit;
  logic [InstLen-1:0] cache_word;
  logic               mem_cmpl, hit_cmpl, load, req;
  logic [InstLen-1:0] mem_word, cmpl_word, load_word;

  // rcv_q==4 only arises when the last byte landed while rdy_in was low.
  assign mem_word  = pend_q ? {mem_byte_in, wbuf_q[23:0]} : wbuf_q;
  assign mem_cmpl  = (state_q == S_FETCH) && ((pend_q && rcv_q == 3'd3) || rcv_q == 3'd4);
  assign hit_cmpl  = cache_hit && (state_q == S_FETCH) && (iss_q == 3'd0) && (rcv_q == 3'd0);
  assign cmpl_word = hit_cmpl ? cache_word : mem_word;
  assign req       = rst_n_in && rdy_in && (state_q == S_FETCH) && (iss_q < 3'd4) && !hit_cmpl;

  assign mem_req_out  = req;
  assign mem_addr_out = pc_in + {29'd0, iss_q};
  assign if_valid_out = vld_q;
  assign if_pc_out    = pc_q;
  assign if_inst_out  = inst_q;

`ifdef ICACHE_EN
  logic fill_en;
  assign fill_en = rdy_in && !flush_in && mem_cmpl;

  icache_dm #(.IDX_W(ICACHE_IDX_W)) u_icache (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .lookup_pc (pc_in),
    .hit       (cache_hit),
    .word      (cache_word),
    .fill_en   (fill_en),
    .fill_pc   (pc_in),
    .fill_word (mem_word)
  );
`else
  logic [ICACHE_IDX_W-1:0] unused_idx;
  assign unused_idx = pc_in[ICACHE_IDX_W+1:2];
  assign cache_hit  = 1'b0;
  assign cache_word = ZeroWord;
`endif

  always_comb begin
    state_d   = state_q;
    iss_d     = iss_q;
    rcv_d     = rcv_q;
    pend_d    = pend_q;
    wbuf_d    = wbuf_q;
    vld_d     = vld_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    load      = 1'b0;
    load_word = wbuf_q;
    if (!rdy_in) begin
      // Frozen, but a byte already granted still has to be kept.
      if (pend_q) begin
        wbuf_d[{rcv_q[1:0], 3'b000} +: 8] = mem_byte_in;
        rcv_d  = rcv_q + 3'd1;
        pend_d = 1'b0;
      end
    end else if (flush_in) begin
      state_d = S_FETCH;
      iss_d   = 3'd0;
      rcv_d   = 3'd0;
      pend_d  = 1'b0;
      vld_d   = 1'b0;
    end else begin
      if (vld_q && !id_stall_in) vld_d = 1'b0;
      pend_d = req && mem_gnt_in;
      if (req && mem_gnt_in) iss_d = iss_q + 3'd1;
      if (pend_q) begin
        wbuf_d[{rcv_q[1:0], 3'b000} +: 8] = mem_byte_in;
        rcv_d = rcv_q + 3'd1;
      end
      if (mem_cmpl || hit_cmpl) begin
        if (!vld_q || !id_stall_in) begin
          load      = 1'b1;
          load_word = cmpl_word;
        end else begin
          state_d = S_WAIT;
          wbuf_d  = cmpl_word;
        end
      end else if (state_q == S_WAIT && !id_stall_in) begin
        load = 1'b1;
      end
      if (load) begin
        state_d = S_FETCH;
        pc_d    = pc_in;
        inst_d  = load_word;
        vld_d   = 1'b1;
        iss_d   = 3'd0;
        rcv_d   = 3'd0;
        pend_d  = 1'b0;
      end
    end
  end

  // One unstalled cycle per delivered word; flush always releases so the jump lands.
  assign stall_req_out = !(rdy_in && (flush_in || load));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_FETCH;
      iss_q   <= 3'd0;
      rcv_q   <= 3'd0;
      pend_q  <= 1'b0;
      wbuf_q  <= ZeroWord;
      vld_q   <= 1'b0;
      pc_q    <= '0;
      inst_q  <= ZeroWord;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
      pend_q  <= pend_d;
      wbuf_q  <= wbuf_d;
      vld_q   <= vld_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a PC-register model and a byte memory model.
module tb_if_fetch;
  logic        clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1, flush_in = 1'b0;
  logic        mem_gnt_in = 1'b1, id_stall_in = 1'b0;
  logic [31:0] pc_in, tgt = 32'd0;
  logic        mem_req_out, stall_req_out, if_valid_out;
  logic [31:0] mem_addr_out, if_pc_out, if_inst_out;
  logic [7:0]  mem_byte_in = 8'h00;
  int          nchk = 0, nerr = 0;

  if_fetch dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .pc_in(pc_in),
    .flush_in(flush_in), .mem_req_out(mem_req_out), .mem_gnt_in(mem_gnt_in),
    .mem_addr_out(mem_addr_out), .mem_byte_in(mem_byte_in),
    .stall_req_out(stall_req_out), .id_stall_in(id_stall_in),
    .if_valid_out(if_valid_out), .if_pc_out(if_pc_out), .if_inst_out(if_inst_out)
  );

  always #5 clk_in = ~clk_in;

  // Memory image: bytes 13 00 00 00 at 0..3, elsewhere a[7:0] + a[9:8]*0x40 + 0x11.
  function automatic logic [7:0] rd(input logic [31:0] a);
    if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
    return a[7:0] + {a[9:8], 6'b000000} + 8'h11;
  endfunction

  always @(posedge clk_in)
    mem_byte_in <= (mem_req_out && mem_gnt_in) ? rd(mem_addr_out) : 8'hEE;

  // PC register: holds on stall, else takes jump target on flush or steps by 4.
  always @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) pc_in <= 32'd0;
    else if (rdy_in && !stall_req_out) pc_in <= flush_in ? tgt : pc_in + 32'd4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic nx(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    nx(2); #1;
    chk("rst_valid", 32'(if_valid_out), 32'd0);
    chk("rst_pc", if_pc_out, 32'd0);
    chk("rst_inst", if_inst_out, 32'd0);
    chk("rst_req", 32'(mem_req_out), 32'd0);
    // cycle 0
    nx(1); rst_n_in = 1'b1; #1;
    chk("c0_req", 32'(mem_req_out), 32'd1);
    chk("c0_addr", mem_addr_out, 32'd0);
    chk("c0_stall", 32'(stall_req_out), 32'd1);
    nx(1); #1; chk("c1_addr", mem_addr_out, 32'd1);
    nx(3); #1;                                        // cycle 4: completion
    chk("c4_stall", 32'(stall_req_out), 32'd0);
    chk("c4_req", 32'(mem_req_out), 32'd0);
    nx(1); #1;                                        // cycle 5
    chk("c5_valid", 32'(if_valid_out), 32'd1);
    chk("c5_pc", if_pc_out, 32'd0);
    chk("c5_inst", if_inst_out, 32'h0000_0013);
    chk("c5_addr", mem_addr_out, 32'd4);
    nx(1); #1; chk("c6_consumed", 32'(if_valid_out), 32'd0);
    nx(4); #1;                                        // cycle 10: back-to-back
    chk("c10_valid", 32'(if_valid_out), 32'd1);
    chk("c10_pc", if_pc_out, 32'd4);
    chk("c10_inst", if_inst_out, 32'h1817_1615);
    chk("c10_addr", mem_addr_out, 32'd8);
    // grant withheld on the second request for 3 cycles
    nx(1); mem_gnt_in = 1'b0; #1;
    chk("c11_addr", mem_addr_out, 32'd9);
    nx(3); mem_gnt_in = 1'b1; #1;
    chk("c14_addr", mem_addr_out, 32'd9);
    chk("c14_stall", 32'(stall_req_out), 32'd1);
    nx(3); #1; chk("c17_stall", 32'(stall_req_out), 32'd0);
    nx(1); id_stall_in = 1'b1; #1;                    // cycle 18
    chk("c18_pc", if_pc_out, 32'd8);
    chk("c18_inst", if_inst_out, 32'h1C1B_1A19);
    // flush while three bytes are in hand, jump to 0x100
    nx(3); flush_in = 1'b1; tgt = 32'h100; #1;        // cycle 21
    chk("c21_flush_stall", 32'(stall_req_out), 32'd0);
    chk("c21_held_valid", 32'(if_valid_out), 32'd1);
    nx(1); flush_in = 1'b0; id_stall_in = 1'b0; #1;   // cycle 22
    chk("c22_valid", 32'(if_valid_out), 32'd0);
    chk("c22_addr", mem_addr_out, 32'h100);
    chk("c22_req", 32'(mem_req_out), 32'd1);
    nx(4); #1; chk("c26_stall", 32'(stall_req_out), 32'd0);
    nx(1); id_stall_in = 1'b1; #1;                    // cycle 27
    chk("c27_pc", if_pc_out, 32'h100);
    chk("c27_inst", if_inst_out, 32'h5453_5251);
    // next word completes with output held -> wait state
    nx(4); #1; chk("c31_stall", 32'(stall_req_out), 32'd1);
    nx(1); #1;                                        // cycle 32
    chk("c32_req", 32'(mem_req_out), 32'd0);
    chk("c32_stall", 32'(stall_req_out), 32'd1);
    chk("c32_pc", if_pc_out, 32'h100);
    nx(2); id_stall_in = 1'b0; #1;                    // cycle 34
    chk("c34_stall", 32'(stall_req_out), 32'd0);
    nx(1); flush_in = 1'b1; tgt = 32'hFFFF_FFFE; #1;  // cycle 35
    chk("c35_valid", 32'(if_valid_out), 32'd1);
    chk("c35_pc", if_pc_out, 32'h104);
    chk("c35_inst", if_inst_out, 32'h5857_5655);
    // address wrap
    nx(1); flush_in = 1'b0; #1;
    chk("c36_addr", mem_addr_out, 32'hFFFF_FFFE);
    nx(1); #1; chk("c37_addr", mem_addr_out, 32'hFFFF_FFFF);
    nx(1); #1; chk("c38_addr", mem_addr_out, 32'h0000_0000);
    nx(1); #1; chk("c39_addr", mem_addr_out, 32'h0000_0001);
    nx(2); rdy_in = 1'b0; #1;                         // cycle 41
    chk("c41_pc", if_pc_out, 32'hFFFF_FFFE);
    chk("c41_inst", if_inst_out, 32'h0013_D0CF);
    chk("c41_rdy_req", 32'(mem_req_out), 32'd0);
    chk("c41_rdy_stall", 32'(stall_req_out), 32'd1);
    nx(1); #1; chk("c42_frozen_valid", 32'(if_valid_out), 32'd1);
    // fetch 0x40, then loop back to it
    nx(1); rdy_in = 1'b1; flush_in = 1'b1; tgt = 32'h40; #1;
    nx(1); flush_in = 1'b0; #1;                       // cycle 44
    chk("c44_addr", mem_addr_out, 32'h40);
    nx(5); flush_in = 1'b1; #1;                       // cycle 49
    chk("c49_inst", if_inst_out, 32'h5453_5251);
    nx(1); flush_in = 1'b0; #1;                       // cycle 50
`ifdef ICACHE_EN
    chk("c50_hit_req", 32'(mem_req_out), 32'd0);
    chk("c50_hit_stall", 32'(stall_req_out), 32'd0);
    nx(1); #1;
    chk("c51_hit_valid", 32'(if_valid_out), 32'd1);
    chk("c51_hit_pc", if_pc_out, 32'h40);
`else
    chk("c50_req", 32'(mem_req_out), 32'd1);
    chk("c50_stall", 32'(stall_req_out), 32'd1);
    chk("c50_addr", mem_addr_out, 32'h40);
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
